// File: rtl/h264_stream_pkg.sv
// h264_stream_pkg: shared state encoding and field constants for the slice bitstream scheduler
package h264_stream_pkg;
  localparam int VL_W = 5;
  localparam int ALIGN_FLAG_BIT = 24;
  typedef enum logic [2:0] {IDLE, HDR, RES, ALIGN, FLUSH} stream_state_t;
endpackage

// File: rtl/h264streamreg.sv
// h264streamreg: output holding register, loads only when empty or being drained
module h264streamreg
  import h264_stream_pkg::*;
#(
  parameter int VEW = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_ld,
  input  logic [VEW-1:0]  i_ve,
  input  logic [VL_W-1:0] i_vl,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [VEW-1:0]  o_ve,
  output logic [VL_W-1:0] o_vl,
  output logic            o_free
);
  assign o_free = !o_valid || i_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_ve    <= '0;
      o_vl    <= '0;
    end else if (i_clr) begin
      o_valid <= 1'b0;
    end else if (o_free) begin
      o_valid <= i_ld;
      if (i_ld) begin
        o_ve <= i_ve;
        o_vl <= i_vl;
      end
    end
  end
endmodule

// File: rtl/h264streamsched.sv
// h264streamsched: per-macroblock header/residual interleaver with rbsp alignment word at slice end
// Optional BITCOUNT output is built when H264_BITCOUNT_EN is defined.
module h264streamsched
  import h264_stream_pkg::*;
#(
  parameter int VEW  = 25,
  parameter int HVEW = 20
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            NEWSLICE,
  input  logic            SLICEEND,
  input  logic            HVALID,
  input  logic [HVEW-1:0] HVE,
  input  logic [4:0]      HVL,
  input  logic            HLAST,
  output logic            HREADY,
  input  logic            CVALID,
  input  logic [VEW-1:0]  CVE,
  input  logic [4:0]      CVL,
  input  logic            CLAST,
  output logic            CREADY,
  output logic            VALID,
  output logic [VEW-1:0]  VE,
  output logic [4:0]      VL,
  input  logic            READY,
  output logic            DONE
`ifdef H264_BITCOUNT_EN
  ,
  output logic [31:0]     BITCOUNT
`endif
);
  stream_state_t   r_state, w_next;
  logic [2:0]      r_bitpos;
  logic            r_pend, r_done;
  logic            w_free, w_hacc, w_cacc, w_ld, w_end, w_flush_acc;
  logic [VEW-1:0]  w_ve, w_align_ve;
  logic [VL_W-1:0] w_vl, w_align_vl;

  assign HREADY      = (r_state == HDR) && w_free;
  assign CREADY      = (r_state == RES) && w_free;
  assign w_hacc      = HVALID && HREADY;
  assign w_cacc      = CVALID && CREADY;
  assign w_end       = r_pend || SLICEEND;
  assign w_flush_acc = (r_state == FLUSH) && VALID && READY;
  assign DONE        = r_done;
  assign w_align_vl  = VL_W'(4'd8 - {1'b0, r_bitpos});
  assign w_align_ve  = (VEW'(1) << ALIGN_FLAG_BIT) | (VEW'(1) << (w_align_vl - 1'b1));
  // zero-length words are consumed without occupying the output register
  assign w_ld = (w_hacc && HVL != '0) || (w_cacc && CVL != '0) || (r_state == ALIGN);
  assign w_ve = (r_state == ALIGN) ? w_align_ve : (r_state == RES) ? CVE : VEW'(HVE);
  assign w_vl = (r_state == ALIGN) ? w_align_vl : (r_state == RES) ? CVL : HVL;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_end ? ALIGN : HVALID ? HDR : IDLE;
      HDR:     w_next = (w_hacc && HLAST) ? RES : HDR;
      RES:     w_next = (w_cacc && CLAST) ? (w_end ? ALIGN : HDR) : RES;
      ALIGN:   w_next = w_free ? FLUSH : ALIGN;
      FLUSH:   w_next = w_flush_acc ? IDLE : FLUSH;
      default: w_next = IDLE;
    endcase
  end

  // the alignment word adds 8-bitpos, which returns bitpos to zero through the same path
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_bitpos <= '0;
      r_done   <= 1'b0;
    end else if (NEWSLICE) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_bitpos <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pend   <= w_flush_acc ? 1'b0 : w_end;
      r_bitpos <= (w_ld && w_free) ? r_bitpos + w_vl[2:0] : r_bitpos;
      r_done   <= w_flush_acc;
    end
  end

  h264streamreg #(.VEW(VEW)) u_reg (
    .clk     (CLK),
    .rst_n   (RESETN),
    .i_clr   (NEWSLICE),
    .i_ld    (w_ld),
    .i_ve    (w_ve),
    .i_vl    (w_vl),
    .i_ready (READY),
    .o_valid (VALID),
    .o_ve    (VE),
    .o_vl    (VL),
    .o_free  (w_free)
  );

`ifdef H264_BITCOUNT_EN
  logic [32:0] w_sum;
  assign w_sum = {1'b0, BITCOUNT} + 33'(VL);
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) BITCOUNT <= '0;
    else if (NEWSLICE) BITCOUNT <= '0;
    else if (VALID && READY) BITCOUNT <= w_sum[32] ? '1 : w_sum[31:0];
  end
`endif
endmodule

// File: tb/tb_h264streamsched.sv
// tb_h264streamsched: directed checks of framing, back-pressure, alignment and slice restart
module tb_h264streamsched;
  import h264_stream_pkg::*;
  logic        CLK, RESETN, NEWSLICE, SLICEEND;
  logic        HVALID, HLAST, HREADY;
  logic [19:0] HVE;
  logic [4:0]  HVL;
  logic        CVALID, CLAST, CREADY;
  logic [24:0] CVE;
  logic [4:0]  CVL;
  logic        VALID, READY, DONE;
  logic [24:0] VE;
  logic [4:0]  VL;
`ifdef H264_BITCOUNT_EN
  logic [31:0] BITCOUNT;
`endif
  logic [29:0] q[$];
  int n_done, n_chk, n_err;

  h264streamsched dut (
    .CLK(CLK), .RESETN(RESETN), .NEWSLICE(NEWSLICE), .SLICEEND(SLICEEND),
    .HVALID(HVALID), .HVE(HVE), .HVL(HVL), .HLAST(HLAST), .HREADY(HREADY),
    .CVALID(CVALID), .CVE(CVE), .CVL(CVL), .CLAST(CLAST), .CREADY(CREADY),
    .VALID(VALID), .VE(VE), .VL(VL), .READY(READY), .DONE(DONE)
`ifdef H264_BITCOUNT_EN
    , .BITCOUNT(BITCOUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (VALID && READY) q.push_back({VE, VL});
    if (DONE) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic chk_w(input string tag, input int i, input logic [24:0] ve, input logic [4:0] vl);
    logic [29:0] got;
    got = (i < q.size()) ? q[i] : '1;
    chk(tag, 32'(got), 32'({ve, vl}));
  endtask

  task automatic send_h(input logic [19:0] ve, input logic [4:0] vl, input logic last);
    bit ok = 0;
    HVALID = 1; HVE = ve; HVL = vl; HLAST = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK); ok = HREADY;
      @(posedge CLK); #1;
    end
    HVALID = 0; HLAST = 0;
    chk("h_accept", 32'(ok), 1);
    if (ok && vl != 0) chk("h_latency", {VALID, 2'b0, VE, VL[3:0]}, {1'b1, 2'b0, {5'b0, ve}, vl[3:0]});
  endtask

  task automatic send_c(input logic [24:0] ve, input logic [4:0] vl, input logic last);
    bit ok = 0;
    CVALID = 1; CVE = ve; CVL = vl; CLAST = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK); ok = CREADY;
      @(posedge CLK); #1;
    end
    CVALID = 0; CLAST = 0;
    chk("c_accept", 32'(ok), 1);
    if (ok && vl != 0) chk("c_latency", {VALID, 2'b0, VE, VL[3:0]}, {1'b1, 2'b0, ve, vl[3:0]});
  endtask

  task automatic wait_done();
    bit d = 0;
    for (int i = 0; i < 50 && !d; i++) begin @(negedge CLK); d = DONE; end
    chk("done_seen", 32'(d), 1);
    cyc(3);
  endtask

  task automatic new_slice();
    NEWSLICE = 1; cyc(); NEWSLICE = 0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_done = 0;
    RESETN = 0; NEWSLICE = 0; SLICEEND = 0; READY = 1;
    HVALID = 0; HVE = 0; HVL = 0; HLAST = 0;
    CVALID = 0; CVE = 0; CVL = 0; CLAST = 0;
    cyc(2);
    chk("rst_outs", {VALID, HREADY, CREADY, DONE}, 0);
    chk("rst_ve", 32'(VE), 0);
    chk("rst_vl", 32'(VL), 0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
`ifdef H264_BITCOUNT_EN
    chk("rst_bitcount", BITCOUNT, 0);
`endif
    RESETN = 1; cyc(3);
    chk("idle_hold", 32'(dut.r_state), 32'(IDLE));

    q.delete();
    send_h(20'h5, 3, 0);
    send_h(20'h1, 1, 1);
    chk("zero_cycle_switch", 32'(CREADY), 1);
    send_c(25'h1F, 5, 0);
    send_c(25'h3, 2, 1);
    cyc(3);
    chk("t1_count", q.size(), 4);
    chk_w("t1_w0", 0, 25'h5, 3);
    chk_w("t1_w1", 1, 25'h1, 1);
    chk_w("t1_w2", 2, 25'h1F, 5);
    chk_w("t1_w3", 3, 25'h3, 2);
    chk("t1_bitpos", 32'(dut.r_bitpos), 3);
    chk("t1_state", 32'(dut.r_state), 32'(HDR));
`ifdef H264_BITCOUNT_EN
    chk("t1_bitcount", BITCOUNT, 11);
`endif

    new_slice();
    q.delete(); n_done = 0;
    send_h(20'h5, 3, 0);
    send_h(20'h1, 1, 1);
    SLICEEND = 1;
    send_c(25'h1F, 5, 0);
    SLICEEND = 0;
    send_c(25'h3, 2, 1);
    wait_done();
    chk("t2_count", q.size(), 5);
    chk_w("t2_align", 4, 25'h1000010, 5);
    chk("t2_done_once", n_done, 1);
    chk("t2_state", 32'(dut.r_state), 32'(IDLE));
`ifdef H264_BITCOUNT_EN
    chk("t2_bitcount", BITCOUNT, 16);
`endif

    new_slice();
    q.delete();
    send_h(20'h7, 3, 0);
    READY = 0; HVALID = 1; HVE = 20'h9; HVL = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_hready", 32'(HREADY), 0);
      chk("stall_hold", {VALID, 2'b0, VE, VL[3:0]}, {1'b1, 2'b0, 25'h7, 4'd3});
    end
    @(posedge CLK); #1;
    READY = 1;
    send_h(20'h9, 2, 0);
    send_h(20'h1, 1, 1);
    cyc(2);
    chk("t3_count", q.size(), 3);
    chk_w("t3_w0", 0, 25'h7, 3);
    chk_w("t3_w1", 1, 25'h9, 2);
    chk_w("t3_w2", 2, 25'h1, 1);
    chk("t3_bitpos", 32'(dut.r_bitpos), 6);

    send_c(25'h0, 0, 1);
    cyc(2);
    chk("t4_count", q.size(), 3);
    chk("t4_valid", 32'(VALID), 0);
    chk("t4_state", 32'(dut.r_state), 32'(HDR));
    chk("t4_bitpos", 32'(dut.r_bitpos), 6);

    new_slice();
    q.delete(); n_done = 0;
    SLICEEND = 1; cyc(); SLICEEND = 0;
    wait_done();
    chk("t5_count", q.size(), 1);
    chk_w("t5_align", 0, 25'h1000080, 8);
    chk("t5_done_once", n_done, 1);
    chk("t5_state", 32'(dut.r_state), 32'(IDLE));
`ifdef H264_BITCOUNT_EN
    chk("t5_bitcount", BITCOUNT, 8);
`endif

    send_h(20'hA, 4, 0);
    READY = 0; cyc();
    chk("t6_held", 32'(VALID), 1);
    NEWSLICE = 1; cyc(); NEWSLICE = 0;
    chk("t6_valid", 32'(VALID), 0);
    chk("t6_state", 32'(dut.r_state), 32'(IDLE));
    chk("t6_bitpos", 32'(dut.r_bitpos), 0);
`ifdef H264_BITCOUNT_EN
    chk("t6_bitcount", BITCOUNT, 0);
`endif
    READY = 1;

    send_h(20'hB, 4, 0);
    READY = 0; #2 RESETN = 0; #1;
    chk("arst_valid", 32'(VALID), 0);
    chk("arst_ve", 32'(VE), 0);
    chk("arst_state", 32'(dut.r_state), 32'(IDLE));
    cyc(); RESETN = 1; READY = 1; cyc(3);
    chk("arst_idle", {VALID, HREADY, CREADY, DONE}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
